carrier_loop_ctrl: RTL
======================

// Module: carrier_loop_ctrl
// PURPOSE
//  Sequencer for the carrier-recovery loop filter in the DSSS demodulator.
//  Gates the filter's per-symbol update strobe, clears its integrator and selects coefficient shifts.
//  Gains are wide-band during acquisition and narrow-band during tracking.
//  Judges lock from the phase-detector magnitude and holds the integrator through short PN-sync dropouts.
//  Sits between PN-sync/despreader (sym_strobe, sync_ok, pd) and the loop filter (load, pd, shifts).
// PARAMETERS
//  PD_W      23       phase-detector word width (signed)
//  ACQ_C1    4        proportional shift in ACQ (c1 = 2^-ACQ_C1)
//  ACQ_C2    9        integral shift in ACQ
//  TRK_C1    5        proportional shift in TRACK
//  TRK_C2    11       integral shift in TRACK
//  LOCK_TH   2^18     |pd| strictly below this counts as a good symbol
//  LOCK_N    64       consecutive good symbols for ACQ->TRACK
//  UNLOCK_N  16       leaky bad-symbol count for TRACK->ACQ
//  HOLD_SYM  32       symbols allowed in HOLD before giving up
// PORTS
//  clk         in   1     system clock, 49.6 MHz
//  rst         in   1     asynchronous, active-high reset
//  sync_ok     in   1     PN-code sync flag, level
//  sym_strobe  in   1     1-cycle pulse, pd valid this cycle; min spacing 4 clk
//  pd          in   PD_W  signed phase-detector output
//  pd_o        out  PD_W  pd registered on sym_strobe, aligned with lf_load
//  lf_load     out  1     1-cycle integrator update strobe to loop filter
//  lf_clear    out  1     synchronous clear of filter integrator, level
//  c1_shift    out  5     proportional shift to filter
//  c2_shift    out  5     integral shift to filter
//  locked      out  1     high only in TRACK
//  state_o     out  2     IDLE=0, ACQ=1, TRACK=2, HOLD=3
// BEHAVIOUR
//  Reset values: state IDLE, pd_o=0, lf_load=0, lf_clear=1, c1/c2=ACQ_C1/ACQ_C2, locked=0, all counters 0.
//  Timing: sym_strobe at cycle t -> pd_o, lf_load=1 at t+1.
//   Counters update at t+1 from pd_o; state/shift/locked change visible at t+2.
//   The load at t+1 therefore uses the pre-transition gains.
//  Magnitude: abs(pd) over PD_W bits; -2^(PD_W-1) saturates to 2^(PD_W-1)-1.
//   good = mag < LOCK_TH.
//  lf_load is issued only in ACQ and TRACK. It is never issued in IDLE or HOLD, and never while lf_clear=1.
//  IDLE: lf_clear=1, counters 0.
//   sync_ok=1 -> ACQ. lf_clear drops in the same cycle the state becomes ACQ.
//  ACQ: shifts ACQ_C1/ACQ_C2.
//   Each strobe: good -> good_cnt+1 (saturating); bad -> good_cnt=0.
//   good_cnt reaching LOCK_N -> TRACK, with bad_cnt=0.
//   sync_ok=0 -> IDLE (clear).
//  TRACK: shifts TRK_C1/TRK_C2, locked=1.
//   Each strobe: bad -> bad_cnt+1; good -> bad_cnt-1, floor 0.
//   bad_cnt reaching UNLOCK_N -> ACQ. good_cnt=0; integrator is kept, not cleared.
//   sync_ok=0 -> HOLD, with hold_cnt=0.
//  HOLD: integrator frozen (no load), shifts unchanged, locked=0.
//   hold_cnt increments per sym_strobe.
//   sync_ok=1 -> TRACK, bad_cnt preserved.
//   hold_cnt reaching HOLD_SYM -> IDLE.
//  Simultaneous events: sync_ok=0 outranks any counter-driven transition in the same cycle.
//   In HOLD, sync return outranks timeout.
//  sym_strobe coinciding with a state change: the strobe is processed under the old state.
//  rst mid-operation returns all outputs to reset values immediately, asynchronously.
// STRUCTURE
//  Shared package (dsss_pkg): state encoding, shift-width constant, default ACQ/TRK shifts.
//  One sub-module: pd_mag_cmp (registered abs with saturation, compare to LOCK_TH, outputs good).
//  Top level holds the FSM, the three counters and output registers. All outputs are registered.
// TESTING
//  1 Reset, then sync_ok=1, 70 strobes with pd=1000.
//    -> ACQ in the cycle after sync_ok.
//    -> TRACK visible 2 clk after the 64th strobe; shifts 5/11; locked=1.
//  2 In ACQ, 63 good strobes, 1 with pd=-2^22, then 64 good.
//    -> good_cnt resets on the bad strobe; TRACK entered only after the 128th strobe.
//  3 In TRACK, alternating bad/good strobes forever.
//    -> bad_cnt oscillates 0/1 and stays in TRACK.
//    Then 16 consecutive pd=300000 -> ACQ; shifts 4/9; lf_clear stays 0.
//  4 In TRACK, drop sync_ok for 10 strobes, then restore.
//    -> HOLD with no lf_load for those 10 strobes; back to TRACK; bad_cnt unchanged.
//  5 In TRACK, drop sync_ok for 32 strobes.
//    -> IDLE after the 32nd; lf_clear=1; locked=0.
//  6 Assert rst during the lf_load cycle.
//    -> lf_load=0 and state IDLE at once; no stray load after release with sync_ok=0.
//    Also: sync_ok fall coinciding with the 64th good strobe -> IDLE, not TRACK.

Source files
------------

// File: rtl/dsss_pkg.sv
// Shared definitions for the DSSS demodulator carrier-recovery sequencer.
package dsss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_HOLD  = 2'd3
  } cl_state_e;

  localparam int SHIFT_W = 5;

  // Default loop-filter shifts: wide-band for acquisition, narrow-band for tracking.
  localparam int DEF_ACQ_C1 = 4;
  localparam int DEF_ACQ_C2 = 9;
  localparam int DEF_TRK_C1 = 5;
  localparam int DEF_TRK_C2 = 11;

  // Symbol counters are wide enough for every threshold and saturate at the top.
  localparam int CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The loop filter may only integrate while acquiring or tracking.
  function automatic logic is_active(input cl_state_e s);
    return (s == ST_ACQ) || (s == ST_TRACK);
  endfunction

endpackage

// File: rtl/pd_mag_cmp.sv
// Registered phase-detector magnitude check: |pd| < LOCK_TH, with the most
// negative code saturated to the largest positive magnitude.
module pd_mag_cmp
  import dsss_pkg::*;
#(
  parameter int PD_W    = 23,
  parameter int LOCK_TH = 1 << 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [PD_W-1:0] pd_i,
  output logic            good_o
);

  localparam logic [PD_W-1:0] MAX_POS = {1'b0, {(PD_W-1){1'b1}}};
  localparam logic [PD_W-1:0] MIN_NEG = {1'b1, {(PD_W-1){1'b0}}};
  localparam logic [PD_W-1:0] TH      = PD_W'(LOCK_TH);

  logic [PD_W-1:0] mag;
  logic            good_q;

  // Two's-complement absolute value; -2^(PD_W-1) has no positive twin.
  always_comb begin
    mag = pd_i;
    if (pd_i == MIN_NEG)   mag = MAX_POS;
    else if (pd_i[PD_W-1]) mag = -pd_i;
  end

  // Capture the verdict alongside the strobed sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       good_q <= 1'b0;
    else if (en_i) good_q <= (mag < TH);
  end

  assign good_o = good_q;

endmodule

// File: rtl/carrier_loop_ctrl.sv
// Carrier-recovery loop sequencer: gates loop-filter updates, clears the
// integrator, selects ACQ/TRACK gains and rides through short sync dropouts.
module carrier_loop_ctrl
  import dsss_pkg::*;
#(
  parameter int PD_W     = 23,
  parameter int ACQ_C1   = DEF_ACQ_C1,
  parameter int ACQ_C2   = DEF_ACQ_C2,
  parameter int TRK_C1   = DEF_TRK_C1,
  parameter int TRK_C2   = DEF_TRK_C2,
  parameter int LOCK_TH  = 1 << 18,
  parameter int LOCK_N   = 64,
  parameter int UNLOCK_N = 16,
  parameter int HOLD_SYM = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync_ok,
  input  logic               sym_strobe,
  input  logic [PD_W-1:0]    pd,
  output logic [PD_W-1:0]    pd_o,
  output logic               lf_load,
  output logic               lf_clear,
  output logic [SHIFT_W-1:0] c1_shift,
  output logic [SHIFT_W-1:0] c2_shift,
  output logic               locked,
  output logic [1:0]         state_o
);

  localparam logic [CNT_W-1:0]   LOCK_N_C   = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0]   UNLOCK_N_C = CNT_W'(UNLOCK_N);
  localparam logic [CNT_W-1:0]   HOLD_SYM_C = CNT_W'(HOLD_SYM);
  localparam logic [SHIFT_W-1:0] ACQ_C1_C   = SHIFT_W'(ACQ_C1);
  localparam logic [SHIFT_W-1:0] ACQ_C2_C   = SHIFT_W'(ACQ_C2);
  localparam logic [SHIFT_W-1:0] TRK_C1_C   = SHIFT_W'(TRK_C1);
  localparam logic [SHIFT_W-1:0] TRK_C2_C   = SHIFT_W'(TRK_C2);

  cl_state_e          state_q, state_d;
  cl_state_e          stb_st_q;
  logic               stb_q;
  logic               mag_good;
  logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]   bad_cnt_q,  bad_cnt_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PD_W-1:0]    pd_q;
  logic               load_q, load_d;
  logic               clear_q;
  logic               locked_q;
  logic [SHIFT_W-1:0] c1_q, c1_d, c2_q, c2_d;
  logic               upd_acq, upd_trk;

  pd_mag_cmp #(
    .PD_W    (PD_W),
    .LOCK_TH (LOCK_TH)
  ) u_mag (
    .clk    (clk),
    .rst    (rst),
    .en_i   (sym_strobe),
    .pd_i   (pd),
    .good_o (mag_good)
  );

  // A counter-driven transition only fires when the judged strobe arrived
  // in the state we are still in.
  assign upd_acq = stb_q && (stb_st_q == ST_ACQ)   && (state_q == ST_ACQ);
  assign upd_trk = stb_q && (stb_st_q == ST_TRACK) && (state_q == ST_TRACK);

  // Counter bookkeeping for last cycle's strobe, then state transitions.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    hold_cnt_d = hold_cnt_q;

    // The strobe is judged under the state it arrived in.
    if (stb_q) begin
      case (stb_st_q)
        ST_ACQ:   good_cnt_d = mag_good ? sat_inc(good_cnt_q) : '0;
        ST_TRACK: bad_cnt_d  = mag_good ? ((bad_cnt_q == '0) ? '0 : bad_cnt_q - CNT_W'(1))
                                        : sat_inc(bad_cnt_q);
        ST_HOLD:  hold_cnt_d = sat_inc(hold_cnt_q);
        default:  ;
      endcase
    end

    // Sync loss outranks counters; sync return outranks the hold timeout.
    case (state_q)
      ST_IDLE: begin
        good_cnt_d = '0;
        bad_cnt_d  = '0;
        hold_cnt_d = '0;
        if (sync_ok) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (!sync_ok) begin
          state_d    = ST_IDLE;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          hold_cnt_d = '0;
        end else if (upd_acq && (good_cnt_d >= LOCK_N_C)) begin
          state_d   = ST_TRACK;
          bad_cnt_d = '0;
        end
      end
      ST_TRACK: begin
        if (!sync_ok) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else if (upd_trk && (bad_cnt_d >= UNLOCK_N_C)) begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (sync_ok) begin
          state_d = ST_TRACK;
        end else if (hold_cnt_d >= HOLD_SYM_C) begin
          state_d    = ST_IDLE;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-state: a load needs an active state both now and next cycle,
  // so it never lands in IDLE/HOLD or under lf_clear. HOLD keeps its gains.
  always_comb begin
    load_d = sym_strobe && is_active(state_q) && is_active(state_d);
    c1_d   = ACQ_C1_C;
    c2_d   = ACQ_C2_C;
    case (state_d)
      ST_TRACK: begin c1_d = TRK_C1_C; c2_d = TRK_C2_C; end
      ST_HOLD:  begin c1_d = c1_q;     c2_d = c2_q;     end
      default:  ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stb_q      <= 1'b0;
      stb_st_q   <= ST_IDLE;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      hold_cnt_q <= '0;
      pd_q       <= '0;
      load_q     <= 1'b0;
      clear_q    <= 1'b1;
      locked_q   <= 1'b0;
      c1_q       <= ACQ_C1_C;
      c2_q       <= ACQ_C2_C;
    end else begin
      state_q    <= state_d;
      stb_q      <= sym_strobe;
      stb_st_q   <= state_q;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      if (sym_strobe) pd_q <= pd;
      load_q     <= load_d;
      clear_q    <= (state_d == ST_IDLE);
      locked_q   <= (state_d == ST_TRACK);
      c1_q       <= c1_d;
      c2_q       <= c2_d;
    end
  end

  assign pd_o     = pd_q;
  assign lf_load  = load_q;
  assign lf_clear = clear_q;
  assign locked   = locked_q;
  assign c1_shift = c1_q;
  assign c2_shift = c2_q;
  assign state_o  = state_q;

endmodule
